pc_stage_sequencer: RTL
=======================

Name: pc_stage_sequencer

Overview:
- Parametrised multi-cycle stage sequencer and program-counter generator for the Core Musa datapath.
- Steps the core through NUM_STAGES execution stages per instruction and holds the current and next PC.
- Latches branch/jump redirects and applies them at instruction boundary.
- Supports stall, halt and a retired-instruction counter; replaces the fixed 3-bit stage / 32-bit next-PC logic in the datapath.

Parameters:
- ADDR_WIDTH, 32: width of pc, npc and redirect_target.
- NUM_STAGES, 5: stages per instruction; legal range 2..8.
- STAGE_W, 3: width of stage output; must satisfy 2^STAGE_W >= NUM_STAGES.
- RESET_PC, 0: pc value after reset.
- PC_INC, 1: sequential PC increment.
- CNT_WIDTH, 16: width of retired_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  freezes stage/pc/counter while high.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  ADDR_WIDTH  target address, qualified by redirect_valid.
- halt_req  in  1  request to stop at next instruction boundary; level-sensitive.
- stage  out  STAGE_W  current stage index, 0..NUM_STAGES-1.
- stage_last  out  1  high when stage == NUM_STAGES-1.
- pc  out  ADDR_WIDTH  address of instruction in flight.
- npc  out  ADDR_WIDTH  registered next PC: pending target if redirect latched, else pc+PC_INC.
- redirect_pending  out  1  a redirect is latched for the current instruction.
- halted  out  1  sequencer parked at stage 0.
- retired_count  out  CNT_WIDTH  instructions completed since reset.

Behaviour:
- Reset (async, any time, including mid-instruction): stage=0, pc=RESET_PC, npc=RESET_PC+PC_INC, redirect_pending=0, halted=0, retired_count=0. All in-flight state is discarded.
- Advance: each clk with stall=0 and halted=0, stage increments by 1. From NUM_STAGES-1 it wraps to 0.
- Instruction boundary (stage==NUM_STAGES-1, advancing):
  - pc<=npc.
  - npc<=new pc+PC_INC.
  - redirect_pending<=0.
  - retired_count<=retired_count+1.
- Redirect capture:
  - When redirect_valid=1 in any non-halted cycle, latch the target and set redirect_pending=1. npc shows the target from the next cycle.
  - Last redirect before the boundary wins.
  - Capture happens even when stall=1.
- Redirect at the boundary cycle itself: the target is used directly as the new pc (npc<=target+PC_INC) and redirect_pending stays 0.
- Stall: stage, pc, npc and retired_count hold. A stall at the last stage delays the boundary update until the first non-stalled cycle.
- Halt:
  - If halt_req=1 at an advancing boundary, the sequencer wraps to stage 0 with pc updated, then sets halted=1 the same edge.
  - While halted: stage holds 0, redirects are ignored, the counter holds.
  - Clearing halt_req resumes on the next edge: halted<=0 and stage starts advancing the following cycle.
- Arithmetic: pc/npc addition is modulo 2^ADDR_WIDTH, so wrap to 0 is legal. retired_count wraps modulo 2^CNT_WIDTH, with no saturation.
- Latency: the PC change is visible the cycle after the boundary edge. stage_last is combinational from stage.
- Unknown-free: no output depends on redirect_target unless redirect_valid was sampled high.

Test Plan:
- Reset then free-run 15 cycles (NUM_STAGES=5, PC_INC=1) -> stage sequence 0,1,2,3,4,0,...; pc 0→1→2 at cycles 5 and 10; retired_count=3 after cycle 15.
- redirect_valid with target 0x100 at stage 2 -> redirect_pending=1, npc=0x100 next cycle; after boundary pc=0x100, npc=0x101, pending=0. Two redirects (0x100 at stage 1, 0x200 at stage 3) -> pc=0x200.
- stall held 3 cycles at stage 4 -> stage stays 4, pc unchanged, count unchanged; boundary fires on first cycle after stall drops.
- halt_req asserted at stage 2 -> completes instruction, halted=1 at stage 0; redirect 0x50 while halted ignored; release -> resumes with pc+1 sequence.
- pc=0xFFFFFFFF at boundary (via redirect) -> next pc=0x00000000; retired_count at 0xFFFF wraps to 0 with CNT_WIDTH=16.
- rst pulsed asynchronously mid-stage 3 with a pending redirect -> outputs return to reset values immediately, without waiting for a clock edge; the pending redirect is lost.

Source files
------------

// File: rtl/pc_stage_sequencer.sv
// Multi-cycle stage sequencer and program-counter generator for the Core Musa datapath.
// Steps NUM_STAGES stages per instruction, applies latched redirects at the instruction boundary.
module pc_stage_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned STAGE_W    = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned PC_INC     = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  halt_req,
    output logic [STAGE_W-1:0]    stage,
    output logic                  stage_last,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] npc,
    output logic                  redirect_pending,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired_count
);

    localparam logic [STAGE_W-1:0]    LastStage = STAGE_W'(NUM_STAGES - 1);
    localparam logic [ADDR_WIDTH-1:0] PcInc     = ADDR_WIDTH'(PC_INC);
    localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e                state;
    logic                  boundary;
    logic [ADDR_WIDTH-1:0] new_pc;

    assign stage_last = (stage == LastStage);
    assign halted     = (state == StHalted);

    always_comb begin
        boundary = 1'b0;
        new_pc   = npc;
        if (state == StRun) begin
            boundary = stage_last && !stall;
            // A redirect arriving on the boundary cycle itself overrides the latched npc.
            if (redirect_valid) begin
                new_pc = redirect_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StRun;
            stage            <= '0;
            pc               <= RESET_PC;
            npc              <= RESET_PC + PcInc;
            redirect_pending <= 1'b0;
            retired_count    <= '0;
        end else begin
            unique case (state)
                StRun: begin
                    if (boundary) begin
                        stage            <= '0;
                        pc               <= new_pc;
                        npc              <= new_pc + PcInc;
                        redirect_pending <= 1'b0;
                        retired_count    <= retired_count + CntOne;
                        if (halt_req) begin
                            state <= StHalted;
                        end
                    end else begin
                        // Redirect capture is allowed during stall; the last one wins.
                        if (redirect_valid) begin
                            npc              <= redirect_target;
                            redirect_pending <= 1'b1;
                        end
                        if (!stall) begin
                            stage <= stage + STAGE_W'(1);
                        end
                    end
                end
                StHalted: begin
                    if (!halt_req) begin
                        state <= StRun;
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

endmodule
